ram_dp_be: RTL and testbench

- Parametrised successor to the team's single-port register-file RAM. One write port and one read port, with byte-lane write enables.
- Read is registered and flagged with a one-cycle valid. Read-during-write behaviour is selectable.
- A hardware clear sequencer zeroes the array after reset or on request.
- Used as the general scratch and buffer memory in later circuit-design datapaths.

---
 rtl/ram_dp_be.sv | 135 +++++++++++++
 tb/tb_ram_dp_be.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/ram_dp_be.sv
// Dual-port (1W/1R) RAM with byte-lane write enables, registered read with valid,
// selectable read-during-write and a hardware clear sequencer.
module ram_dp_be #(
  parameter int unsigned N          = 4,
  parameter int unsigned M          = 16,
  parameter int unsigned B          = 8,
  parameter int unsigned RDW_MODE   = 0,
  parameter int unsigned CLR_ON_RST = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  output logic             busy,
  input  logic             we,
  input  logic [N-1:0]     wadr,
  input  logic [M/B-1:0]   wbe,
  input  logic [M-1:0]     din,
  input  logic             re,
  input  logic [N-1:0]     radr,
  output logic [M-1:0]     dout,
  output logic             dvalid
);

  localparam int unsigned L     = M / B;
  localparam int unsigned DEPTH = 2 ** N;

  if ((M % B) != 0) begin : g_bad_lane_cfg
    $error("ram_dp_be: data width M must be a multiple of lane width B");
  end

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   cnt_q, cnt_d;
  logic [M-1:0]   dout_q, dout_d;
  logic           dvalid_q, dvalid_d;

  logic [M-1:0]   mem [DEPTH];

  logic           idle_c;
  logic           wr_en_c;
  logic [N-1:0]   wr_adr_c;
  logic [M-1:0]   wr_data_c;
  logic [L-1:0]   wr_lane_c;
  logic [M-1:0]   be_mask_c;
  logic           rd_en_c;
  logic           rdw_hit_c;
  logic [M-1:0]   rd_old_c;
  logic [M-1:0]   rd_merged_c;

  assign idle_c = (state_q == IDLE);
  assign busy   = (state_q == CLEAR);
  assign dout   = dout_q;
  assign dvalid = dvalid_q;

  // Clear sequencer next-state: walks cnt over every word, then returns to IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (clr) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        cnt_d = cnt_q + N'(1);
        if (cnt_q == '1) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Write port mux: the sequencer owns the array while clearing.
  always_comb begin
    for (int unsigned i = 0; i < L; i++) begin
      be_mask_c[i*B +: B] = {B{wbe[i]}};
    end
    wr_en_c   = we;
    wr_adr_c  = wadr;
    wr_data_c = din;
    wr_lane_c = wbe;
    if (!idle_c) begin
      wr_en_c   = 1'b1;
      wr_adr_c  = cnt_q;
      wr_data_c = '0;
      wr_lane_c = '1;
    end
  end

  // Read path: old word by default, merged word on a same-address hit when RDW_MODE=1.
  always_comb begin
    rd_en_c     = re & idle_c;
    rdw_hit_c   = we & idle_c & (wadr == radr);
    rd_old_c    = mem[radr];
    rd_merged_c = (rd_old_c & ~be_mask_c) | (din & be_mask_c);
    dout_d      = dout_q;
    dvalid_d    = rd_en_c;
    if (rd_en_c) begin
      dout_d = ((RDW_MODE == 1) && rdw_hit_c) ? rd_merged_c : rd_old_c;
    end
  end

  // Array storage has no reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      for (int unsigned i = 0; i < L; i++) begin
        if (wr_lane_c[i]) begin
          mem[wr_adr_c][i*B +: B] <= wr_data_c[i*B +: B];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= (CLR_ON_RST != 0) ? CLEAR : IDLE;
      cnt_q    <= '0;
      dout_q   <= '0;
      dvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dout_q   <= dout_d;
      dvalid_q <= dvalid_d;
    end
  end

endmodule

// File: tb/tb_ram_dp_be.sv
// Directed bench for ram_dp_be: both RDW modes side by side, checked against
// a behavioural memory model and a read-result scoreboard.
module tb_ram_dp_be;

  localparam int unsigned N     = 4;
  localparam int unsigned M     = 16;
  localparam int unsigned B     = 8;
  localparam int unsigned L     = M / B;
  localparam int unsigned DEPTH = 2 ** N;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clr;
  logic          we;
  logic [N-1:0]  wadr;
  logic [L-1:0]  wbe;
  logic [M-1:0]  din;
  logic          re;
  logic [N-1:0]  radr;
  logic          busy0, busy1;
  logic [M-1:0]  dout0, dout1;
  logic          dvalid0, dvalid1;

  int            checks   = 0;
  int            failures = 0;
  logic [M-1:0]  mdl [DEPTH];
  int            clr_rem;
  logic [M-1:0]  q0 [$];
  logic [M-1:0]  q1 [$];
  logic [M-1:0]  hold0, hold1;
  logic          exp_valid;

  always #5 clk = ~clk;

  ram_dp_be #(.N(N), .M(M), .B(B), .RDW_MODE(0), .CLR_ON_RST(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .busy(busy0), .we(we), .wadr(wadr),
    .wbe(wbe), .din(din), .re(re), .radr(radr), .dout(dout0), .dvalid(dvalid0)
  );

  ram_dp_be #(.N(N), .M(M), .B(B), .RDW_MODE(1), .CLR_ON_RST(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .busy(busy1), .we(we), .wadr(wadr),
    .wbe(wbe), .din(din), .re(re), .radr(radr), .dout(dout1), .dvalid(dvalid1)
  );

  task automatic chk(input string tag, input logic [M-1:0] obs, input logic [M-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus: model predicts busy, writes and read results, then checks.
  task automatic cycle(input logic c, input logic w, input logic [N-1:0] wa,
                       input logic [L-1:0] be, input logic [M-1:0] d,
                       input logic r, input logic [N-1:0] ra);
    logic [M-1:0] old_w;
    logic [M-1:0] mrg_w;
    clr = c; we = w; wadr = wa; wbe = be; din = d; re = r; radr = ra;
    #1;
    chk("busy_m0", M'(busy0), M'(clr_rem > 0));
    chk("busy_m1", M'(busy1), M'(clr_rem > 0));
    exp_valid = 1'b0;
    if (clr_rem == 0 && r) begin
      old_w = mdl[ra];
      mrg_w = old_w;
      for (int i = 0; i < L; i++) if (be[i]) mrg_w[i*B +: B] = d[i*B +: B];
      q0.push_back(old_w);
      q1.push_back((w && wa == ra) ? mrg_w : old_w);
      exp_valid = 1'b1;
    end
    if (clr_rem > 0) begin
      mdl[N'(DEPTH - clr_rem)] = '0;
      clr_rem--;
    end else begin
      if (w) for (int i = 0; i < L; i++) if (be[i]) mdl[wa][i*B +: B] = d[i*B +: B];
      if (c) clr_rem = DEPTH;
    end
    @(posedge clk);
    #1;
    chk("dvalid_m0", M'(dvalid0), M'(exp_valid));
    chk("dvalid_m1", M'(dvalid1), M'(exp_valid));
    if (exp_valid) begin
      hold0 = q0.pop_front();
      hold1 = q1.pop_front();
    end
    chk("dout_m0", dout0, hold0);
    chk("dout_m1", dout1, hold1);
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, '0, '0, '0, 1'b0, '0);
  endtask

  task automatic wr(input logic [N-1:0] a, input logic [M-1:0] d, input logic [L-1:0] be);
    cycle(1'b0, 1'b1, a, be, d, 1'b0, '0);
  endtask

  task automatic rd(input logic [N-1:0] a);
    cycle(1'b0, 1'b0, '0, '0, '0, 1'b1, a);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_dout_m0"}, dout0, '0);
    chk({tag, "_dout_m1"}, dout1, '0);
    chk({tag, "_dvalid_m0"}, M'(dvalid0), '0);
    chk({tag, "_dvalid_m1"}, M'(dvalid1), '0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n   = 1'b1;
    clr_rem = DEPTH;
    q0.delete();
    q1.delete();
    hold0   = '0;
    hold1   = '0;
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; we = 1'b0; wadr = '0; wbe = '0; din = '0;
    re = 1'b0; radr = '0; clr_rem = 0; hold0 = '0; hold1 = '0; exp_valid = 1'b0;
    #1;
    chk_reset_outputs("por");
    repeat (2) @(posedge clk);
    release_reset();

    // Power-on clear: busy for exactly DEPTH cycles, then all words read zero.
    repeat (DEPTH) idle();
    idle();
    for (int a = 0; a < DEPTH; a++) rd(N'(a));
    idle();

    // Byte-lane writes.
    wr(4'd3, 16'hABCD, 2'b11);
    wr(4'd3, 16'h1234, 2'b01);
    rd(4'd3);
    wr(4'd3, 16'hFFFF, 2'b00);
    rd(4'd3);
    idle();

    // Read-during-write, then independent different-address read/write.
    wr(4'd5, 16'h1111, 2'b11);
    cycle(1'b0, 1'b1, 4'd5, 2'b10, 16'h2222, 1'b1, 4'd5);
    rd(4'd5);
    cycle(1'b0, 1'b1, 4'd8, 2'b11, 16'h8888, 1'b1, 4'd3);
    rd(4'd8);
    idle();

    // Hold and wrap.
    wr(4'd15, 16'h00F0, 2'b11);
    wr(4'd0, 16'h0A0A, 2'b11);
    rd(4'd15);
    repeat (3) idle();
    rd(4'd0);
    idle();

    // Software clear with blocked access and an ignored re-trigger.
    for (int a = 0; a < DEPTH; a++) wr(N'(a), 16'hFFFF, 2'b11);
    cycle(1'b1, 1'b0, '0, '0, '0, 1'b0, '0);
    cycle(1'b0, 1'b1, 4'd2, 2'b11, 16'h5555, 1'b1, 4'd2);
    cycle(1'b1, 1'b0, '0, '0, '0, 1'b0, '0);
    for (int k = 0; k < 2 * DEPTH && clr_rem > 0; k++) idle();
    idle();
    for (int a = 0; a < DEPTH; a++) rd(N'(a));
    idle();

    // Reset mid-read: valid read data dropped asynchronously.
    wr(4'd7, 16'h7777, 2'b11);
    rd(4'd7);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("rst_mid_read");
    release_reset();

    // Reset mid-clear at cnt=7, then a full restart of the clear.
    repeat (7) idle();
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("rst_mid_clear");
    release_reset();
    repeat (DEPTH) idle();
    idle();
    for (int a = 0; a < DEPTH; a++) rd(N'(a));
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before end of stimulus");
    $fatal(1, "watchdog");
  end

endmodule
